// File: rtl/pulse_seq_pkg.sv
// Shared state encoding and flat-bus slicing helpers for the pulse sequencer.
package pulse_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_SEG   = 2'd2
   } state_t;

   localparam logic [15:0] OVERRUN_SAT = 16'hFFFF;

   function automatic int bank_lsb(input int bank, input int w);
      return bank * w;
   endfunction

   function automatic int seg_lsb(input int bank, input int seg, input int nseg, input int w);
      return ((bank * nseg) + seg) * w;
   endfunction

endpackage

// File: rtl/pulse_seq_trig_sync.sv
// Brings the asynchronous zero-crossing strobe into a_clk and emits a one-cycle
// event on its rising edge, with the bank select captured alongside it.
module pulse_seq_trig_sync #(
   parameter int DIR_W = 1
) (
   input  logic             a_clk,
   input  logic             a_rst,
   input  logic             trig_zero,
   input  logic [DIR_W-1:0] trig_dir,
   output logic             evt,
   output logic [DIR_W-1:0] evt_dir
);

   logic [2:0]       sync_r;
   logic [DIR_W-1:0] dir1_r;
   logic [DIR_W-1:0] dir2_r;

   // Synchroniser chain, edge detect and direction capture
   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         sync_r  <= 3'b000;
         dir1_r  <= '0;
         dir2_r  <= '0;
         evt     <= 1'b0;
         evt_dir <= '0;
      end else begin
         sync_r <= {sync_r[1:0], trig_zero};
         dir1_r <= trig_dir;
         dir2_r <= dir1_r;
         evt    <= sync_r[1] & ~sync_r[2];
         if (sync_r[1] & ~sync_r[2]) begin
            evt_dir <= dir2_r;
         end
      end
   end

endmodule

// File: rtl/pulse_seq_gen.sv
// Zero-crossing-triggered multi-segment pulse sequencer: per-bank delay followed
// by NSEG (width, height) segments, framed by pre/post bias levels.
module pulse_seq_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16,
   parameter int NSEG       = 4,
   parameter int NBANK      = 2,
   parameter int DECIM_LOG2 = 2
) (
   input  logic                                  a_clk,
   input  logic                                  a_rst,
   input  logic                                  trig_zero,
   input  logic [$clog2(NBANK)-1:0]              trig_dir,
   input  logic                                  cfg_enable,
   input  logic                                  cfg_alternate,
   input  logic [NBANK*CNT_WIDTH-1:0]            cfg_delay,
   input  logic [NBANK*NSEG*CNT_WIDTH-1:0]       cfg_width,
   input  logic [NBANK*NSEG*DATA_WIDTH-1:0]      cfg_height,
   input  logic [DATA_WIDTH-1:0]                 cfg_bias_pre,
   input  logic [DATA_WIDTH-1:0]                 cfg_bias_post,
   output logic [DATA_WIDTH-1:0]                 M_AXIS_tdata,
   output logic                                  M_AXIS_tvalid,
   output logic                                  busy,
   output logic [$clog2(NBANK)-1:0]              active_bank,
   output logic [((NSEG > 1) ? $clog2(NSEG) : 1)-1:0] seg_index,
   output logic [15:0]                           overrun_count
);
   import pulse_seq_pkg::*;

   localparam int BANK_W = $clog2(NBANK);
   localparam int SEG_W  = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic                  evt_s;
   logic [BANK_W-1:0]     evt_dir_s;
   logic                  tick_s;
   logic                  accept_s;
   logic                  overrun_inc_s;
   logic [CNT_WIDTH-1:0]  cfg_delay_sel_s;

   state_t                state_r, state_nx_s;
   logic [CNT_WIDTH-1:0]  cnt_r, cnt_nx_s;
   logic [SEG_W-1:0]      seg_r, seg_nx_s;
   logic [SEG_W-1:0]      nxt_idx_s;
   logic                  nxt_found_s;
   logic [DATA_WIDTH-1:0] tdata_r, tdata_nx_s;
   logic                  busy_r, busy_nx_s;
   logic                  tvalid_r;
   logic [BANK_W-1:0]     last_bank_r;
   logic                  last_vld_r;
   logic [15:0]           overrun_r;

   logic [CNT_WIDTH-1:0]  width_sh_r  [NSEG];
   logic [DATA_WIDTH-1:0] height_sh_r [NSEG];
   logic [DATA_WIDTH-1:0] pre_sh_r;
   logic [DATA_WIDTH-1:0] post_sh_r;

   pulse_seq_trig_sync #(.DIR_W(BANK_W)) u_trig_sync (
      .a_clk     (a_clk),
      .a_rst     (a_rst),
      .trig_zero (trig_zero),
      .trig_dir  (trig_dir),
      .evt       (evt_s),
      .evt_dir   (evt_dir_s)
   );

   generate
      if (DECIM_LOG2 == 0) begin : g_nodiv
         assign tick_s = 1'b1;
      end else begin : g_div
         logic [DECIM_LOG2-1:0] div_r;
         // Free-running tick divider
         always_ff @(posedge a_clk or posedge a_rst) begin
            if (a_rst) begin
               div_r <= '0;
            end else begin
               div_r <= div_r + DECIM_LOG2'(1);
            end
         end
         assign tick_s = (div_r == '0);
      end
   endgenerate

   assign cfg_delay_sel_s = cfg_delay[bank_lsb(int'(evt_dir_s), CNT_WIDTH) +: CNT_WIDTH];

   // Lowest-index segment after the current one with a nonzero width
   always_comb begin
      logic hit_v;
      hit_v       = 1'b0;
      nxt_found_s = 1'b0;
      nxt_idx_s   = '0;
      for (int i = NSEG - 1; i >= 0; i--) begin
         hit_v       = ((state_r == ST_DELAY) || (i > int'(seg_r))) && (width_sh_r[i] != '0);
         nxt_found_s = nxt_found_s | hit_v;
         nxt_idx_s   = hit_v ? SEG_W'(i) : nxt_idx_s;
      end
   end

   // Next-state and next-output logic; sequencing advances only on ticks
   always_comb begin
      state_nx_s    = state_r;
      cnt_nx_s      = cnt_r;
      seg_nx_s      = seg_r;
      tdata_nx_s    = tdata_r;
      busy_nx_s     = busy_r;
      accept_s      = 1'b0;
      overrun_inc_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (evt_s && cfg_enable && (!cfg_alternate || !last_vld_r || (evt_dir_s != last_bank_r))) begin
               accept_s   = 1'b1;
               state_nx_s = ST_DELAY;
               cnt_nx_s   = cfg_delay_sel_s;
               seg_nx_s   = '0;
            end else if (tick_s) begin
               tdata_nx_s = post_sh_r;
               busy_nx_s  = 1'b0;
               seg_nx_s   = '0;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_DELAY, ST_SEG: begin
            overrun_inc_s = evt_s;
            if (!tick_s) begin
               state_nx_s = state_r;
            end else if (!cfg_enable || ((cnt_r == '0) && !nxt_found_s)) begin
               state_nx_s = ST_IDLE;
               cnt_nx_s   = '0;
               seg_nx_s   = '0;
               tdata_nx_s = post_sh_r;
               busy_nx_s  = 1'b0;
            end else if (cnt_r != '0) begin
               cnt_nx_s   = cnt_r - CNT_ONE;
               tdata_nx_s = (state_r == ST_DELAY) ? pre_sh_r : height_sh_r[seg_r];
               busy_nx_s  = 1'b1;
            end else begin
               state_nx_s = ST_SEG;
               seg_nx_s   = nxt_idx_s;
               cnt_nx_s   = width_sh_r[nxt_idx_s] - CNT_ONE;
               tdata_nx_s = height_sh_r[nxt_idx_s];
               busy_nx_s  = 1'b1;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = '0;
            seg_nx_s   = '0;
            tdata_nx_s = '0;
            busy_nx_s  = 1'b0;
         end
      endcase
   end

   // FSM state, counters, output registers, bank history and overrun counter
   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         seg_r       <= '0;
         tdata_r     <= '0;
         busy_r      <= 1'b0;
         tvalid_r    <= 1'b0;
         last_bank_r <= '0;
         last_vld_r  <= 1'b0;
         overrun_r   <= 16'h0000;
      end else begin
         state_r  <= state_nx_s;
         cnt_r    <= cnt_nx_s;
         seg_r    <= seg_nx_s;
         tdata_r  <= tdata_nx_s;
         busy_r   <= busy_nx_s;
         tvalid_r <= 1'b1;
         if (accept_s) begin
            last_bank_r <= evt_dir_s;
            last_vld_r  <= 1'b1;
         end
         if (overrun_inc_s && (overrun_r != OVERRUN_SAT)) begin
            overrun_r <= overrun_r + 16'd1;
         end
      end
   end

   // Shadow copy of the accepted bank's configuration
   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         pre_sh_r  <= '0;
         post_sh_r <= '0;
         for (int k = 0; k < NSEG; k++) begin
            width_sh_r[k]  <= '0;
            height_sh_r[k] <= '0;
         end
      end else if (accept_s) begin
         pre_sh_r  <= cfg_bias_pre;
         post_sh_r <= cfg_bias_post;
         for (int k = 0; k < NSEG; k++) begin
            width_sh_r[k]  <= cfg_width[seg_lsb(int'(evt_dir_s), k, NSEG, CNT_WIDTH) +: CNT_WIDTH];
            height_sh_r[k] <= cfg_height[seg_lsb(int'(evt_dir_s), k, NSEG, DATA_WIDTH) +: DATA_WIDTH];
         end
      end
   end

   assign M_AXIS_tdata  = tdata_r;
   assign M_AXIS_tvalid = tvalid_r;
   assign busy          = busy_r;
   assign active_bank   = last_bank_r;
   assign seg_index     = seg_r;
   assign overrun_count = overrun_r;

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Scoreboard bench for pulse_seq_gen: a small model pushes the expected per-tick
// samples when a trigger is driven; they are popped as the DUT produces them.
module tb_pulse_seq_gen;

   typedef struct packed {
      logic [15:0] d;
      logic        b;
      logic [1:0]  s;
   } smp_t;

   logic        a_clk = 1'b0;
   logic        a_rst = 1'b1;
   logic        trig_zero = 1'b0;
   logic        trig4 = 1'b0;
   logic [0:0]  trig_dir = 1'b0;
   logic        cfg_enable = 1'b1;
   logic        cfg_alternate = 1'b0;
   logic [31:0]  cfg_delay;
   logic [127:0] cfg_width;
   logic [127:0] cfg_height;
   logic [15:0] cfg_bias_pre = 16'd10;
   logic [15:0] cfg_bias_post = 16'hFFFB;

   logic [15:0] dly [2];
   logic [15:0] wid [2][4];
   logic [15:0] hgt [2][4];

   logic [15:0] tdata, tdata4, ovr, ovr4;
   logic        tvalid, tvalid4, busy, busy4;
   logic [0:0]  bank, bank4;
   logic [1:0]  seg, seg4;

   smp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   nbusy;

   pulse_seq_gen #(.DATA_WIDTH(16), .CNT_WIDTH(16), .NSEG(4), .NBANK(2), .DECIM_LOG2(0)) u_dut (
      .a_clk(a_clk), .a_rst(a_rst), .trig_zero(trig_zero), .trig_dir(trig_dir),
      .cfg_enable(cfg_enable), .cfg_alternate(cfg_alternate), .cfg_delay(cfg_delay),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_bias_pre(cfg_bias_pre),
      .cfg_bias_post(cfg_bias_post), .M_AXIS_tdata(tdata), .M_AXIS_tvalid(tvalid),
      .busy(busy), .active_bank(bank), .seg_index(seg), .overrun_count(ovr));

   pulse_seq_gen #(.DATA_WIDTH(16), .CNT_WIDTH(16), .NSEG(4), .NBANK(2), .DECIM_LOG2(2)) u_dut4 (
      .a_clk(a_clk), .a_rst(a_rst), .trig_zero(trig4), .trig_dir(trig_dir),
      .cfg_enable(cfg_enable), .cfg_alternate(cfg_alternate), .cfg_delay(cfg_delay),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_bias_pre(cfg_bias_pre),
      .cfg_bias_post(cfg_bias_post), .M_AXIS_tdata(tdata4), .M_AXIS_tvalid(tvalid4),
      .busy(busy4), .active_bank(bank4), .seg_index(seg4), .overrun_count(ovr4));

   always #5 a_clk = ~a_clk;

   always_comb begin
      cfg_delay  = '0;
      cfg_width  = '0;
      cfg_height = '0;
      for (int b = 0; b < 2; b++) begin
         cfg_delay[b*16 +: 16] = dly[b];
         for (int k = 0; k < 4; k++) begin
            cfg_width[(b*4+k)*16 +: 16]  = wid[b][k];
            cfg_height[(b*4+k)*16 +: 16] = hgt[b][k];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push1(input logic [15:0] d, input logic b, input int s, input int rep);
      smp_t e;
      e.d = d;
      e.b = b;
      e.s = 2'(s);
      for (int r = 0; r < rep; r++) exp_q.push_back(e);
   endtask

   // model: delay ticks at pre, each nonzero segment for its width, then post once
   task automatic push_run(input int bk, input int rep);
      for (int t = 0; t < int'(dly[bk]); t++) push1(cfg_bias_pre, 1'b1, 0, rep);
      for (int k = 0; k < 4; k++)
         for (int t = 0; t < int'(wid[bk][k]); t++) push1(hgt[bk][k], 1'b1, k, rep);
      push1(cfg_bias_post, 1'b0, 0, 1);
   endtask

   task automatic fire(input logic d, input bit sel);
      if (sel) trig4 = 1'b0; else trig_zero = 1'b0;
      repeat (3) @(negedge a_clk);
      trig_dir = d;
      if (sel) trig4 = 1'b1; else trig_zero = 1'b1;
   endtask

   task automatic drain(input bit sel, input int drop_at, output int busy_cnt);
      smp_t e;
      int   n;
      int   w;
      busy_cnt = 0;
      w = 0;
      while (((sel ? busy4 : busy) !== 1'b1) && (w < 24)) begin
         @(negedge a_clk);
         w++;
      end
      check("start_busy", {31'd0, (sel ? busy4 : busy)}, 32'd1);
      if ((sel ? busy4 : busy) !== 1'b1) begin
         exp_q.delete();
      end else begin
         n = 0;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tdata", {16'd0, (sel ? tdata4 : tdata)}, {16'd0, e.d});
            check("busy", {31'd0, (sel ? busy4 : busy)}, {31'd0, e.b});
            check("seg", {30'd0, (sel ? seg4 : seg)}, {30'd0, e.s});
            if ((sel ? busy4 : busy) === 1'b1) busy_cnt++;
            if (n == drop_at) cfg_enable = 1'b0;
            n++;
            @(negedge a_clk);
         end
      end
   endtask

   task automatic set_t1;
      dly[0] = 16'd3;
      wid[0][0] = 16'd2; wid[0][1] = 16'd0; wid[0][2] = 16'd4; wid[0][3] = 16'd1;
      hgt[0][0] = 16'd100; hgt[0][1] = 16'd777; hgt[0][2] = -16'sd200; hgt[0][3] = 16'd50;
      dly[1] = 16'd1;
      wid[1][0] = 16'd1; wid[1][1] = 16'd3; wid[1][2] = 16'd0; wid[1][3] = 16'd0;
      hgt[1][0] = 16'd7; hgt[1][1] = -16'sd7; hgt[1][2] = 16'd0; hgt[1][3] = 16'd0;
      cfg_bias_pre = 16'd10;
      cfg_bias_post = -16'sd5;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      set_t1();
      repeat (2) @(negedge a_clk);
      check("rst_tdata", {16'd0, tdata}, 32'd0);
      check("rst_tvalid", {31'd0, tvalid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ovr", {16'd0, ovr}, 32'd0);
      check("rst_bank", {31'd0, bank}, 32'd0);
      a_rst = 1'b0;
      @(negedge a_clk);
      check("tvalid_up", {31'd0, tvalid}, 32'd1);
      repeat (2) @(negedge a_clk);
      check("idle_post0", {16'd0, tdata}, 32'd0);

      // T1 basic sequence
      push_run(0, 1);
      fire(1'b0, 1'b0);
      drain(1'b0, -1, nbusy);
      check("t1_busy_ticks", nbusy, 32'd10);

      // T4 decimated tick on the second instance
      dly[0] = 16'd0;
      wid[0][0] = 16'd1; wid[0][2] = 16'd0; wid[0][3] = 16'd0;
      hgt[0][0] = 16'd1234;
      push_run(0, 4);
      fire(1'b0, 1'b1);
      drain(1'b1, -1, nbusy);
      check("t4_busy_clks", nbusy, 32'd4);
      set_t1();

      // T3 one trigger during a run
      push_run(0, 1);
      fire(1'b0, 1'b0);
      fork
         drain(1'b0, -1, nbusy);
         begin
            repeat (4) @(negedge a_clk);
            trig_zero = 1'b0;
            repeat (3) @(negedge a_clk);
            trig_zero = 1'b1;
         end
      join
      check("t3_ovr1", {16'd0, ovr}, 32'd1);

      // T3 saturation, starting near the top of the counter
      @(negedge a_clk);
      force u_dut.overrun_r = 16'hFFFD;
      @(negedge a_clk);
      release u_dut.overrun_r;
      dly[0] = 16'd30;
      push_run(0, 1);
      fire(1'b0, 1'b0);
      fork
         drain(1'b0, -1, nbusy);
         begin
            repeat (4) @(negedge a_clk);
            for (int j = 0; j < 4; j++) begin
               trig_zero = 1'b0;
               repeat (2) @(negedge a_clk);
               trig_zero = 1'b1;
               repeat (2) @(negedge a_clk);
            end
         end
      join
      check("t3_ovr_sat", {16'd0, ovr}, 32'h0000FFFF);
      dly[0] = 16'd3;

      // T5 enable drop in segment 1, then a normal rerun
      push_run(1, 1);
      exp_q.delete(3);
      exp_q.delete(3);
      fire(1'b1, 1'b0);
      drain(1'b0, 2, nbusy);
      check("t5_bank", {31'd0, bank}, 32'd1);
      cfg_enable = 1'b1;
      push_run(1, 1);
      fire(1'b1, 1'b0);
      drain(1'b0, -1, nbusy);

      // T6 async reset during DELAY, config writes ignored while running
      dly[0] = 16'd20;
      fire(1'b0, 1'b0);
      for (int w = 0; (w < 24) && (busy !== 1'b1); w++) @(negedge a_clk);
      check("t6_busy", {31'd0, busy}, 32'd1);
      repeat (3) @(negedge a_clk);
      cfg_bias_pre = 16'd99;
      dly[0] = 16'd1;
      hgt[0][0] = 16'd55;
      @(negedge a_clk);
      check("t6_cfg_hold", {16'd0, tdata}, 32'd10);
      a_rst = 1'b1;
      #1;
      check("t6_tdata", {16'd0, tdata}, 32'd0);
      check("t6_busy0", {31'd0, busy}, 32'd0);
      check("t6_ovr", {16'd0, ovr}, 32'd0);
      check("t6_tvalid", {31'd0, tvalid}, 32'd0);
      @(negedge a_clk);
      a_rst = 1'b0;
      set_t1();
      trig_zero = 1'b0;
      repeat (3) @(negedge a_clk);

      // T2 alternation: dir 0, 0, 1 -> first and third run
      cfg_alternate = 1'b1;
      push_run(0, 1);
      fire(1'b0, 1'b0);
      drain(1'b0, -1, nbusy);
      fire(1'b0, 1'b0);
      nbusy = 0;
      repeat (15) begin
         @(negedge a_clk);
         if (busy === 1'b1) nbusy++;
      end
      check("t2_reject", nbusy, 32'd0);
      check("t2_bank0", {31'd0, bank}, 32'd0);
      push_run(1, 1);
      fire(1'b1, 1'b0);
      drain(1'b0, -1, nbusy);
      check("t2_bank1", {31'd0, bank}, 32'd1);
      check("t2_ovr", {16'd0, ovr}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
